// File: rtl/hwpe_stream_source_realign_ctrl.sv
// Address/strobe sequencer for a 2D (lines x words) source transfer feeding a TCDM load port and realigner.
// Optional performance counters (stall/beat) are built when HWPE_REALIGN_CTRL_PERF_EN is defined.
module hwpe_stream_source_realign_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [CNT_WIDTH-1:0]    line_length_i,
    input  logic [CNT_WIDTH-1:0]    n_lines_i,
    input  logic [ADDR_WIDTH-1:0]   line_stride_i,
    output logic [ADDR_WIDTH-1:0]   addr_o,
    output logic                    addr_valid_o,
    input  logic                    addr_ready_i,
    output logic [DATA_WIDTH/8-1:0] strb_o,
    output logic                    strb_valid_o,
    output logic                    first_o,
    output logic                    last_o,
    output logic                    last_packet_o,
    output logic                    realign_o,
    output logic [CNT_WIDTH-1:0]    line_length_o,
    output logic                    enable_o,
    output logic                    busy_o,
    output logic                    done_o
`ifdef HWPE_REALIGN_CTRL_PERF_EN
    ,
    output logic [31:0]             stall_cnt_o,
    output logic [31:0]             beat_cnt_o
`endif
);

    localparam int unsigned BW    = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BW);
    localparam logic [ADDR_WIDTH-1:0] BW_INC     = ADDR_WIDTH'(BW);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BW - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [OFF_W-1:0]      off_q;
    logic                  realign_q;
    logic [CNT_WIDTH:0]    wpl_q;
    logic [CNT_WIDTH:0]    word_cnt_q;
    logic [CNT_WIDTH-1:0]  n_lines_q;
    logic [CNT_WIDTH-1:0]  line_cnt_q;
    logic [CNT_WIDTH-1:0]  line_length_q;
    logic [ADDR_WIDTH-1:0] line_ptr_q;
    logic [ADDR_WIDTH-1:0] cur_ptr_q;
    logic [ADDR_WIDTH-1:0] stride_q;

    logic                  run;
    logic                  accept;
    logic                  start_ok;
    logic                  degenerate;
    logic                  last_word;
    logic                  last_line;
    logic [OFF_W-1:0]      off_in;
    logic [ADDR_WIDTH-1:0] next_line_ptr;

    // Partial strobes only appear on the edge words of a misaligned line.
    function automatic logic [BW-1:0] word_strb(input logic realign, input logic first,
                                                input logic last, input logic [OFF_W-1:0] off);
        logic [BW-1:0] ones;
        ones = '1;
        if (!realign) return ones;
        if (first)    return ones << off;
        if (last)     return ~(ones << off);
        return ones;
    endfunction

    assign off_in        = base_addr_i[OFF_W-1:0];
    assign run           = (state_q == RUN);
    assign accept        = run & addr_ready_i;
    assign start_ok      = (state_q == IDLE) & start_i;
    assign degenerate    = (line_length_i == '0) || (n_lines_i == '0);
    assign last_word     = (word_cnt_q == (wpl_q - (CNT_WIDTH+1)'(1)));
    assign last_line     = (line_cnt_q == (n_lines_q - CNT_WIDTH'(1)));
    assign next_line_ptr = line_ptr_q + stride_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = degenerate ? DRAIN : RUN;
            RUN:     if (accept && last_word && last_line) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      state_q <= IDLE;
        else if (clear_i) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Configuration latch and address/counter walk; clear drops the whole context.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            off_q         <= '0;
            realign_q     <= 1'b0;
            wpl_q         <= '0;
            word_cnt_q    <= '0;
            n_lines_q     <= '0;
            line_cnt_q    <= '0;
            line_length_q <= '0;
            line_ptr_q    <= '0;
            cur_ptr_q     <= '0;
            stride_q      <= '0;
        end else if (clear_i) begin
            off_q         <= '0;
            realign_q     <= 1'b0;
            wpl_q         <= '0;
            word_cnt_q    <= '0;
            n_lines_q     <= '0;
            line_cnt_q    <= '0;
            line_length_q <= '0;
            line_ptr_q    <= '0;
            cur_ptr_q     <= '0;
            stride_q      <= '0;
        end else if (start_ok) begin
            off_q         <= off_in;
            realign_q     <= (off_in != '0);
            wpl_q         <= {1'b0, line_length_i} + (CNT_WIDTH+1)'(off_in != '0);
            word_cnt_q    <= '0;
            n_lines_q     <= n_lines_i;
            line_cnt_q    <= '0;
            line_length_q <= line_length_i;
            line_ptr_q    <= base_addr_i & ALIGN_MASK;
            cur_ptr_q     <= base_addr_i & ALIGN_MASK;
            stride_q      <= line_stride_i & ALIGN_MASK;
        end else if (accept) begin
            if (last_word) begin
                word_cnt_q <= '0;
                if (!last_line) begin
                    line_cnt_q <= line_cnt_q + CNT_WIDTH'(1);
                    line_ptr_q <= next_line_ptr;
                    cur_ptr_q  <= next_line_ptr;
                end
            end else begin
                word_cnt_q <= word_cnt_q + (CNT_WIDTH+1)'(1);
                cur_ptr_q  <= cur_ptr_q + BW_INC;
            end
        end
    end

    assign addr_valid_o  = run;
    assign addr_o        = run ? cur_ptr_q : '0;
    assign first_o       = run & (word_cnt_q == '0);
    assign last_o        = run & last_word;
    assign last_packet_o = run & last_word & last_line;
    assign strb_o        = run ? word_strb(realign_q, word_cnt_q == '0, last_word, off_q) : '1;
    assign strb_valid_o  = accept;
    assign realign_o     = realign_q;
    assign line_length_o = line_length_q;
    assign enable_o      = (state_q == RUN) | (state_q == DRAIN);
    assign busy_o        = (state_q != IDLE);
    assign done_o        = (state_q == DRAIN);

`ifdef HWPE_REALIGN_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] beat_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else if (clear_i || start_ok) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            if (run && !addr_ready_i) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (accept)               beat_cnt_q  <= sat_inc(beat_cnt_q);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign beat_cnt_o  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_hwpe_stream_source_realign_ctrl.sv
// Randomized self-checking bench for hwpe_stream_source_realign_ctrl (BW = 4) against a lines x words reference model.
module tb_hwpe_stream_source_realign_ctrl;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        first;
        logic        last;
        logic        lp;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n, clear, start, ready;
    logic [31:0] base_addr, line_stride;
    logic [15:0] line_length, n_lines;
    logic [31:0] addr_o;
    logic        addr_valid_o, strb_valid_o, first_o, last_o, last_packet_o;
    logic [3:0]  strb_o;
    logic        realign_o, enable_o, busy_o, done_o;
    logic [15:0] line_length_o;
`ifdef HWPE_REALIGN_CTRL_PERF_EN
    logic [31:0] stall_cnt, beat_cnt;
`endif

    beat_t got[$];
    beat_t exp[$];
    int total = 0;
    int bad = 0;
    int done_cnt, done_cyc, last_acc, stalls, sv_err, hold_err, en_err;
    bit timed_out, idle_after;
    logic rl0;
    logic [15:0] ll0;

    always #5 clk = ~clk;

    hwpe_stream_source_realign_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .clear_i       (clear),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .line_length_i (line_length),
        .n_lines_i     (n_lines),
        .line_stride_i (line_stride),
        .addr_o        (addr_o),
        .addr_valid_o  (addr_valid_o),
        .addr_ready_i  (ready),
        .strb_o        (strb_o),
        .strb_valid_o  (strb_valid_o),
        .first_o       (first_o),
        .last_o        (last_o),
        .last_packet_o (last_packet_o),
        .realign_o     (realign_o),
        .line_length_o (line_length_o),
        .enable_o      (enable_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
`ifdef HWPE_REALIGN_CTRL_PERF_EN
        ,
        .stall_cnt_o   (stall_cnt),
        .beat_cnt_o    (beat_cnt)
`endif
    );

    // Reference: enumerate lines and words directly from the transfer description.
    function automatic void build_exp(input logic [31:0] b, input int ln, input int nls, input logic [31:0] st);
        int off;
        int wpl;
        logic [31:0] a;
        logic [3:0] s;
        beat_t e;
        exp.delete();
        off = int'(b[1:0]);
        wpl = ln + ((off != 0) ? 1 : 0);
        if (ln == 0 || nls == 0) return;
        for (int l = 0; l < nls; l++) begin
            for (int w = 0; w < wpl; w++) begin
                a = (b & ~32'h3) + l * (st & ~32'h3) + w * 4;
                if (off == 0)          s = 4'hF;
                else if (w == 0)       s = 4'(15 << off);
                else if (w == wpl - 1) s = 4'(~(15 << off));
                else                   s = 4'hF;
                e = {a, s, (w == 0), (w == wpl - 1), (w == wpl - 1) && (l == nls - 1)};
                exp.push_back(e);
            end
        end
    endfunction

    // Drives one transfer and records what the DUT presented; comparisons live in the test tasks.
    task automatic run_xfer(input logic [31:0] b, input int ln, input int nls, input logic [31:0] st,
                            input int mode, input bit poke);
        beat_t cur, prev;
        bit prev_stall;
        int bp_stall;
        got.delete();
        done_cnt = 0; done_cyc = -1; last_acc = -1; stalls = 0;
        sv_err = 0; hold_err = 0; en_err = 0; timed_out = 1;
        prev_stall = 0; bp_stall = 0; prev = '0;
        @(negedge clk);
        base_addr = b; line_length = ln[15:0]; n_lines = nls[15:0]; line_stride = st; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            case (mode)
                0:       ready = 1'b1;
                1:       ready = 1'($urandom_range(0, 1));
                default: ready = !(got.size() == 1 && bp_stall < 3);
            endcase
            start = poke && (cyc == 2);
            if (poke && cyc == 2) begin
                base_addr = 32'h0000_0803; line_length = 16'd7; n_lines = 16'd5;
            end
            #1;
            cur = {addr_o, strb_o, first_o, last_o, last_packet_o};
            if (cyc == 0) begin rl0 = realign_o; ll0 = line_length_o; end
            if (strb_valid_o !== (addr_valid_o & ready)) sv_err++;
            if (busy_o !== 1'b1 || enable_o !== 1'b1) en_err++;
            if (prev_stall && addr_valid_o && cur !== prev) hold_err++;
            prev_stall = addr_valid_o & ~ready;
            if (addr_valid_o && !ready) begin
                stalls++;
                if (got.size() == 1) bp_stall++;
            end
            if (addr_valid_o && ready) begin
                got.push_back(cur);
                last_acc = cyc;
            end
            prev = cur;
            if (done_o) begin
                done_cnt++; done_cyc = cyc; timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        #1;
        if (done_o) done_cnt++;
        idle_after = !busy_o && !addr_valid_o;
    endtask

    task automatic test_reset();
        logic [60:0] obs;
        logic [60:0] req;
        req = {1'b0, 32'h0, 4'hF, 3'b000, 1'b0, 16'h0, 4'b0000};
        rst_n = 1'b0; ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        obs = {addr_valid_o, addr_o, strb_o, first_o, last_o, last_packet_o, realign_o,
               line_length_o, enable_o, busy_o, done_o, strb_valid_o};
        total++;
        if (obs !== req) begin bad++; $display("FAIL reset_outputs got=%h req=%h", obs, req); end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        obs = {addr_valid_o, addr_o, strb_o, first_o, last_o, last_packet_o, realign_o,
               line_length_o, enable_o, busy_o, done_o, strb_valid_o};
        total++;
        if (obs !== req) begin bad++; $display("FAIL post_reset_idle got=%h req=%h", obs, req); end
`ifdef HWPE_REALIGN_CTRL_PERF_EN
        total++;
        if ({stall_cnt, beat_cnt} !== 64'h0) begin
            bad++; $display("FAIL reset_perf got=%h req=0", {stall_cnt, beat_cnt});
        end
`endif
        ready = 1'b0;
    endtask

    task automatic test_aligned();
        build_exp(32'h100, 3, 2, 32'h20);
        run_xfer(32'h100, 3, 2, 32'h20, 0, 0);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL aligned_count got=%0d req=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL aligned_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
        total++;
        if (timed_out || done_cyc != last_acc + 1 || done_cnt != 1) begin
            bad++; $display("FAIL aligned_done got cyc=%0d cnt=%0d req cyc=%0d cnt=1", done_cyc, done_cnt, last_acc + 1);
        end
        total++;
        if (rl0 !== 1'b0 || sv_err != 0 || en_err != 0 || !idle_after) begin
            bad++; $display("FAIL aligned_ctrl got realign=%b sv_err=%0d en_err=%0d idle=%0b req 0/0/0/1", rl0, sv_err, en_err, idle_after);
        end
    endtask

    task automatic test_misaligned();
        build_exp(32'h102, 3, 1, 32'h0);
        run_xfer(32'h102, 3, 1, 32'h0, 0, 0);
        total++;
        if (got.size() != 4) begin bad++; $display("FAIL mis_count got=%0d req=4", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL mis_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
        total++;
        if (rl0 !== 1'b1 || ll0 !== 16'd3) begin
            bad++; $display("FAIL mis_realign got realign=%b len=%0d req realign=1 len=3", rl0, ll0);
        end
        total++;
        if (timed_out || done_cyc != last_acc + 1) begin
            bad++; $display("FAIL mis_done got=%0d req=%0d", done_cyc, last_acc + 1);
        end
    endtask

    task automatic test_backpressure();
        build_exp(32'h102, 3, 1, 32'h0);
        run_xfer(32'h102, 3, 1, 32'h0, 2, 0);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL bp_count got=%0d req=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL bp_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
        total++;
        if (hold_err != 0 || sv_err != 0 || stalls != 3) begin
            bad++; $display("FAIL bp_hold got hold_err=%0d sv_err=%0d stalls=%0d req 0/0/3", hold_err, sv_err, stalls);
        end
`ifdef HWPE_REALIGN_CTRL_PERF_EN
        total++;
        if (stall_cnt !== 32'd3 || beat_cnt !== 32'd4) begin
            bad++; $display("FAIL bp_perf got stall=%0d beat=%0d req stall=3 beat=4", stall_cnt, beat_cnt);
        end
`endif
    endtask

    task automatic test_single_word();
        build_exp(32'h40, 1, 3, 32'h10);
        run_xfer(32'h40, 1, 3, 32'h10, 1, 0);
        total++;
        if (got.size() != 3) begin bad++; $display("FAIL single_count got=%0d req=3", got.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL single_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_abort();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        base_addr = 32'h100; line_length = 16'd3; n_lines = 16'd2; line_stride = 32'h20; start = 1'b1;
        @(negedge clk);
        start = 1'b0; ready = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (addr_valid_o !== 1'b1 || addr_o !== 32'h104) begin
            bad++; $display("FAIL abort_beat2 got valid=%b addr=%h req valid=1 addr=104", addr_valid_o, addr_o);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0; ready = 1'b0;
        #1;
        total++;
        if ({addr_valid_o, busy_o, done_o, enable_o} !== 4'b0000) begin
            bad++; $display("FAIL abort_idle got=%b req=0000", {addr_valid_o, busy_o, done_o, enable_o});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (done_o) seen_done++;
        end
        total++;
        if (seen_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d req=0", seen_done); end
        build_exp(32'h100, 3, 2, 32'h20);
        run_xfer(32'h100, 3, 2, 32'h20, 0, 0);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL abort_rerun_count got=%0d req=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL abort_rerun_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_degenerate();
        run_xfer(32'h100, 3, 0, 32'h20, 0, 0);
        total++;
        if (got.size() != 0 || timed_out || done_cyc != 0 || done_cnt != 1) begin
            bad++; $display("FAIL degen_lines got beats=%0d done_cyc=%0d done_cnt=%0d req 0/0/1", got.size(), done_cyc, done_cnt);
        end
        run_xfer(32'h101, 0, 2, 32'h20, 0, 0);
        total++;
        if (got.size() != 0 || timed_out || done_cyc != 0 || done_cnt != 1) begin
            bad++; $display("FAIL degen_len got beats=%0d done_cyc=%0d done_cnt=%0d req 0/0/1", got.size(), done_cyc, done_cnt);
        end
        build_exp(32'h100, 3, 2, 32'h20);
        run_xfer(32'h100, 3, 2, 32'h20, 0, 1);
        total++;
        if (got.size() != exp.size()) begin bad++; $display("FAIL poke_count got=%0d req=%0d", got.size(), exp.size()); end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin bad++; $display("FAIL poke_beat%0d got=%h req=%h", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] b, st;
        int ln, nls;
        for (int it = 0; it < 10; it++) begin
            b = $urandom; st = $urandom;
            if (it == 0) b = 32'hFFFF_FFF1;
            ln = $urandom_range(1, 5); nls = $urandom_range(1, 3);
            build_exp(b, ln, nls, st);
            run_xfer(b, ln, nls, st, 1, 0);
            total++;
            if (got.size() != exp.size()) begin bad++; $display("FAIL rand%0d_count got=%0d req=%0d", it, got.size(), exp.size()); end
            for (int i = 0; i < exp.size() && i < got.size(); i++) begin
                total++;
                if (got[i] !== exp[i]) begin bad++; $display("FAIL rand%0d_beat%0d got=%h req=%h", it, i, got[i], exp[i]); end
            end
            total++;
            if (timed_out || done_cyc != last_acc + 1 || hold_err != 0 || sv_err != 0 || rl0 !== (b[1:0] != 2'b00)) begin
                bad++; $display("FAIL rand%0d_ctrl got done_cyc=%0d hold=%0d sv=%0d realign=%b req done_cyc=%0d 0 0 %b",
                                it, done_cyc, hold_err, sv_err, rl0, last_acc + 1, (b[1:0] != 2'b00));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; start = 1'b0; ready = 1'b0;
        base_addr = '0; line_length = '0; n_lines = '0; line_stride = '0;
        test_reset();
        test_aligned();
        test_misaligned();
        test_backpressure();
        test_single_word();
        test_abort();
        test_degenerate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
